// File: rtl/adc_trig_capture.sv
// Write-side producer for the circular display line buffer: decimation, level/edge trigger, frame gating.
// Optional feature: define PEAK_DETECT_EN to decimate by window maximum instead of last sample.
module adc_trig_capture #(
    parameter int LEN     = 800,
    parameter int PRE_LEN = 400,
    parameter int DIV_W   = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             adc_valid,
    input  logic [7:0]       adc_data,
    input  logic [DIV_W-1:0] decim,
    input  logic [1:0]       mode,
    input  logic [7:0]       trig_level,
    input  logic             trig_edge,
    input  logic             arm,
    output logic             wr_en,
    output logic [7:0]       wr_data,
    output logic             triggered,
    output logic             frame_done
);

    localparam int CW = $clog2(LEN);
    localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    PRE_LAST = CW'(PRE_LEN - 1);
    localparam logic [CW-1:0]    Q_LOAD   = CW'(LEN - 1 - PRE_LEN);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ARMED,
        POST,
        HOLD
    } state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] dcnt;
    logic [DIV_W-1:0] n_eff;
    logic [DIV_W-1:0] n_last;
    logic             stb;
    logic [7:0]       sample;
    logic [7:0]       prev;
    logic             prev_vld;
    logic             clr_prev;
    logic [1:0]       mode_q;
    logic             mode_chg;
    logic             trig_hit;
    logic [CW-1:0]    pcnt, pcnt_n;
    logic [CW-1:0]    qcnt, qcnt_n;
    logic             do_write;
    logic             done_n;

    // A window closes on the valid where dcnt has reached N-1; a shrinking decim
    // that leaves dcnt past the new limit simply closes on the next valid.
    assign n_eff  = (decim == '0) ? DIV_ONE : decim;
    assign n_last = n_eff - DIV_ONE;
    assign stb    = adc_valid && (dcnt >= n_last);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dcnt <= '0;
        end else if (adc_valid) begin
            dcnt <= stb ? '0 : dcnt + DIV_ONE;
        end
    end

`ifdef PEAK_DETECT_EN
    logic [7:0] acc;
    logic       acc_vld;

    assign sample = (acc_vld && (acc > adc_data)) ? acc : adc_data;

    // acc_vld drops at each window close so the next window reloads from its first sample.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            acc     <= '0;
            acc_vld <= 1'b0;
        end else if (adc_valid) begin
            if (stb) begin
                acc_vld <= 1'b0;
            end else begin
                acc     <= sample;
                acc_vld <= 1'b1;
            end
        end
    end
`else
    assign sample = adc_data;
`endif

    assign mode_chg = (mode != mode_q);

    assign trig_hit = prev_vld && (trig_edge ?
                      ((prev > trig_level) && (sample <= trig_level)) :
                      ((prev < trig_level) && (sample >= trig_level)));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q   <= 2'b00;
            prev     <= '0;
            prev_vld <= 1'b0;
        end else begin
            mode_q <= mode;
            if (clr_prev) begin
                prev_vld <= 1'b0;
            end else if (stb) begin
                prev     <= sample;
                prev_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
            pcnt  <= '0;
            qcnt  <= '0;
        end else begin
            state <= state_n;
            pcnt  <= pcnt_n;
            qcnt  <= qcnt_n;
        end
    end

    // Any mode change restarts the frame from IDLE; dcnt deliberately survives it.
    always_comb begin
        state_n  = state;
        pcnt_n   = pcnt;
        qcnt_n   = qcnt;
        do_write = 1'b0;
        done_n   = 1'b0;
        clr_prev = 1'b0;
        if (mode_chg) begin
            state_n  = IDLE;
            pcnt_n   = '0;
            qcnt_n   = '0;
            clr_prev = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (mode == 2'b00) begin
                        do_write = stb;
                    end else begin
                        state_n  = PRE;
                        pcnt_n   = '0;
                        clr_prev = 1'b1;
                    end
                end
                PRE: begin
                    if (stb) begin
                        do_write = 1'b1;
                        if (pcnt == PRE_LAST) begin
                            state_n = ARMED;
                            pcnt_n  = '0;
                        end else begin
                            pcnt_n = pcnt + CNT_ONE;
                        end
                    end
                end
                ARMED: begin
                    if (stb) begin
                        do_write = 1'b1;
                        if (trig_hit) begin
                            state_n = POST;
                            qcnt_n  = Q_LOAD;
                        end
                    end
                end
                POST: begin
                    if (stb) begin
                        do_write = 1'b1;
                        if (qcnt == CNT_ONE) begin
                            done_n = 1'b1;
                            qcnt_n = '0;
                            if (mode == 2'b10) begin
                                state_n = HOLD;
                            end else begin
                                state_n  = PRE;
                                pcnt_n   = '0;
                                clr_prev = 1'b1;
                            end
                        end else begin
                            qcnt_n = qcnt - CNT_ONE;
                        end
                    end
                end
                HOLD: begin
                    if (arm) begin
                        state_n  = PRE;
                        pcnt_n   = '0;
                        clr_prev = 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_en      <= 1'b0;
            wr_data    <= '0;
            triggered  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            wr_en      <= do_write;
            frame_done <= done_n;
            triggered  <= (state_n == POST) || (state_n == HOLD);
            if (do_write) begin
                wr_data <= sample;
            end
        end
    end

endmodule

// File: tb/tb_adc_trig_capture.sv
// Scoreboard bench for adc_trig_capture: a behavioural model pushes expected writes, a negedge monitor pops them.
// Follows PEAK_DETECT_EN the same way as the design.
module tb_adc_trig_capture;

    localparam int LEN     = 800;
    localparam int PRE_LEN = 400;
    localparam int DIV_W   = 16;

`ifdef PEAK_DETECT_EN
    localparam int PEAK_EXPECT = 200;
`else
    localparam int PEAK_EXPECT = 40;
`endif

    logic             sys_clk = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic             adc_valid = 1'b0;
    logic [7:0]       adc_data = '0;
    logic [DIV_W-1:0] decim = 16'd1;
    logic [1:0]       mode = 2'b00;
    logic [7:0]       trig_level = 8'd128;
    logic             trig_edge = 1'b0;
    logic             arm = 1'b0;
    logic             wr_en;
    logic [7:0]       wr_data;
    logic             triggered;
    logic             frame_done;

    adc_trig_capture #(.LEN(LEN), .PRE_LEN(PRE_LEN), .DIV_W(DIV_W)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .adc_valid  (adc_valid),
        .adc_data   (adc_data),
        .decim      (decim),
        .mode       (mode),
        .trig_level (trig_level),
        .trig_edge  (trig_edge),
        .arm        (arm),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .triggered  (triggered),
        .frame_done (frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    typedef enum int {M_ROLL, M_PRE, M_ARMED, M_POST, M_HOLD} mstate_t;
    typedef struct packed {
        logic [7:0] data;
        logic       done;
        logic       trig;
    } exp_t;

    exp_t    expQ[$];
    exp_t    monE;
    int      checks = 0;
    int      errors = 0;
    int      wrSeen = 0;
    int      doneSeen = 0;
    int      lastData = 0;

    mstate_t mState = M_ROLL;
    int      mDcnt = 0;
    int      mPcnt = 0;
    int      mPostLeft = 0;
    logic [7:0] mPrev = '0;
    logic       mPrevVld = 1'b0;
    logic [7:0] mAcc = '0;
    logic       mAccVld = 1'b0;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] triWave(input int i, input int offs);
        int p;
        p = i % 64;
        return 8'(((p < 32) ? p * 8 : (63 - p) * 8) + offs);
    endfunction

    // Behavioural model of one input cycle, evaluated before the clock edge that consumes it.
    task automatic modelStep(input logic v, input logic [7:0] d, input logic a);
        int n;
        logic stb;
        logic hit;
        logic enterPre;
        logic wr;
        logic [7:0] s;
        exp_t e;
        if (v) begin
            n = (decim == '0) ? 1 : int'(decim);
`ifdef PEAK_DETECT_EN
            s = (mAccVld && (mAcc > d)) ? mAcc : d;
`else
            s = d;
`endif
            stb = (mDcnt >= n - 1);
            mDcnt = stb ? 0 : mDcnt + 1;
            if (stb) begin
                mAccVld = 1'b0;
            end else begin
                mAcc = s;
                mAccVld = 1'b1;
            end
            if (stb) begin
                hit = mPrevVld && (trig_edge ? ((mPrev > trig_level) && (s <= trig_level))
                                             : ((mPrev < trig_level) && (s >= trig_level)));
                enterPre = 1'b0;
                wr = (mState != M_HOLD);
                e.done = 1'b0;
                case (mState)
                    M_PRE: begin
                        mPcnt++;
                        if (mPcnt == PRE_LEN) mState = M_ARMED;
                    end
                    M_ARMED: begin
                        if (hit) begin
                            mState = M_POST;
                            mPostLeft = LEN - 1 - PRE_LEN;
                        end
                    end
                    M_POST: begin
                        mPostLeft--;
                        if (mPostLeft == 0) begin
                            e.done = 1'b1;
                            if (mode == 2'b10) begin
                                mState = M_HOLD;
                            end else begin
                                mState = M_PRE;
                                mPcnt = 0;
                                enterPre = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
                if (enterPre) begin
                    mPrevVld = 1'b0;
                end else begin
                    mPrev = s;
                    mPrevVld = 1'b1;
                end
                if (wr) begin
                    e.data = s;
                    e.trig = (mState == M_POST) || (mState == M_HOLD);
                    expQ.push_back(e);
                end
            end
        end
        if (a && (mState == M_HOLD)) begin
            mState = M_PRE;
            mPcnt = 0;
            mPrevVld = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic a);
        adc_valid = v;
        adc_data  = d;
        arm       = a;
        modelStep(v, d, a);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("pending_writes", expQ.size(), 0);
    endtask

    task automatic setMode(input logic [1:0] m);
        mode = m;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'd0, 1'b0);
        mState = (m == 2'b00) ? M_ROLL : M_PRE;
        mPcnt = 0;
        mPostLeft = 0;
        mPrevVld = 1'b0;
    endtask

    task automatic doReset();
        sys_rst_n = 1'b0;
        #2;
        checkOutput("reset_wr_en", 32'(wr_en), 0);
        checkOutput("reset_wr_data", 32'(wr_data), 0);
        checkOutput("reset_triggered", 32'(triggered), 0);
        checkOutput("reset_frame_done", 32'(frame_done), 0);
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        expQ.delete();
        mDcnt = 0;
        mAcc = '0;
        mAccVld = 1'b0;
        mPrev = '0;
        mPrevVld = 1'b0;
        mPcnt = 0;
        mPostLeft = 0;
        mState = (mode == 2'b00) ? M_ROLL : M_PRE;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'd0, 1'b0);
    endtask

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            checkOutput("frame_done_without_wr", 32'(frame_done & ~wr_en), 0);
            if (wr_en === 1'b1) begin
                wrSeen++;
                lastData = 32'(wr_data);
                if (frame_done === 1'b1) doneSeen++;
                checkOutput("wr_en_expected", 32'(wr_en), 32'(expQ.size() != 0));
                if (expQ.size() != 0) begin
                    monE = expQ.pop_front();
                    checkOutput("wr_data", 32'(wr_data), 32'(monE.data));
                    checkOutput("frame_done", 32'(frame_done), 32'(monE.done));
                    checkOutput("triggered", 32'(triggered), 32'(monE.trig));
                end
            end
        end
    end

    initial begin
        int w0;
        int d0;
        int cnt;

        $display("[TB] reset");
        doReset();

        $display("[TB] roll N=1 ramp");
        w0 = wrSeen;
        for (int i = 0; i < 256; i++) applyStimulus(1'b1, 8'(i), 1'b0);
        drain();
        checkOutput("roll_n1_writes", wrSeen - w0, 256);
        checkOutput("roll_n1_last", lastData, 255);

        $display("[TB] roll N=4 ramp, then N=0");
        decim = 16'd4;
        w0 = wrSeen;
        for (int i = 0; i < 256; i++) applyStimulus(1'b1, 8'(i), 1'b0);
        drain();
        checkOutput("roll_n4_writes", wrSeen - w0, 64);
        checkOutput("roll_n4_last", lastData, 255);
        decim = 16'd0;
        w0 = wrSeen;
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(i + 50), 1'b0);
        drain();
        checkOutput("roll_n0_writes", wrSeen - w0, 8);
        decim = 16'd1;

        $display("[TB] normal mode rising 128");
        trig_level = 8'd128;
        trig_edge  = 1'b0;
        setMode(2'b01);
        w0 = wrSeen;
        d0 = doneSeen;
        for (int i = 0; i < 900; i++) applyStimulus(1'b1, triWave(i, 0), 1'b0);
        drain();
        checkOutput("normal_writes", wrSeen - w0, 900);
        checkOutput("normal_frames", doneSeen - d0, 1);
        checkOutput("normal_back_to_pre", 32'(triggered), 0);

        $display("[TB] single mode");
        setMode(2'b10);
        d0 = doneSeen;
        for (int i = 0; i < 900; i++) applyStimulus(1'b1, triWave(i, 0), (i == 100) ? 1'b1 : 1'b0);
        drain();
        checkOutput("single_frames", doneSeen - d0, 1);
        checkOutput("single_hold_triggered", 32'(triggered), 1);
        w0 = wrSeen;
        for (int i = 0; i < 10000; i++) applyStimulus(1'b1, triWave(i, 0), 1'b0);
        drain();
        checkOutput("hold_no_writes", wrSeen - w0, 0);
        applyStimulus(1'b0, 8'd0, 1'b1);
        w0 = wrSeen;
        for (int i = 0; i < 50; i++) applyStimulus(1'b1, triWave(i, 0), 1'b0);
        drain();
        checkOutput("rearm_writes", wrSeen - w0, 50);
        checkOutput("rearm_triggered", 32'(triggered), 0);

        $display("[TB] falling level 0");
        trig_edge  = 1'b1;
        trig_level = 8'd0;
        setMode(2'b01);
        w0 = wrSeen;
        d0 = doneSeen;
        for (int i = 0; i < 600; i++) applyStimulus(1'b1, triWave(i, 4), 1'b0);
        drain();
        checkOutput("falling0_writes", wrSeen - w0, 600);
        checkOutput("falling0_frames", doneSeen - d0, 0);
        checkOutput("falling0_triggered", 32'(triggered), 0);

        $display("[TB] reset mid-POST");
        trig_edge  = 1'b0;
        trig_level = 8'd128;
        setMode(2'b00);
        setMode(2'b01);
        cnt = 0;
        while ((mState != M_POST) && (cnt < 2000)) begin
            applyStimulus(1'b1, triWave(cnt, 0), 1'b0);
            cnt++;
        end
        for (int i = 0; i < 50; i++) applyStimulus(1'b1, triWave(cnt + i, 0), 1'b0);
        drain();
        checkOutput("mid_post_triggered", 32'(triggered), 1);
        doReset();
        w0 = wrSeen;
        for (int i = 0; i < PRE_LEN; i++) applyStimulus(1'b1, triWave(i + 20, 0), 1'b0);
        drain();
        checkOutput("post_reset_pre_writes", wrSeen - w0, PRE_LEN);
        checkOutput("post_reset_triggered", 32'(triggered), 0);

        $display("[TB] window peak");
        setMode(2'b00);
        doReset();
        decim = 16'd4;
        applyStimulus(1'b1, 8'd10, 1'b0);
        applyStimulus(1'b1, 8'd200, 1'b0);
        applyStimulus(1'b1, 8'd30, 1'b0);
        applyStimulus(1'b1, 8'd40, 1'b0);
        drain();
        checkOutput("peak_window", lastData, PEAK_EXPECT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
